// File: rtl/noc_pkg.sv
// Shared NoC buffer constants: default flit width, default almost-levels and
// the occupancy-count width helper.
package noc_pkg;

  localparam int NOC_FLIT_W       = 8;
  localparam int NOC_ALMOST_EMPTY = 2;
  localparam int NOC_ALMOST_FULL  = 14;

  // The count must hold 0..2^depth_log2 inclusive, hence one extra bit.
  function automatic int noc_count_w(input int depth_log2);
    return depth_log2 + 1;
  endfunction

endpackage

// File: rtl/noc_buf_mem.sv
// Flit storage for the router input buffer: register array with synchronous
// write and asynchronous read; contents are never reset.
module noc_buf_mem
  import noc_pkg::*;
#(
  parameter int DATA_WIDTH = NOC_FLIT_W,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [DEPTH_LOG2-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/noc_input_buffer.sv
// Router input-port FIFO with valid/ready on both sides, occupancy count and
// almost flags. Define NOC_BUF_BYPASS_EN for first-word fall-through when empty.
module noc_input_buffer
  import noc_pkg::*;
#(
  parameter int DATA_WIDTH         = NOC_FLIT_W,
  parameter int DEPTH_LOG2         = 4,
  parameter int ALMOST_EMPTY_LEVEL = NOC_ALMOST_EMPTY,
  parameter int ALMOST_FULL_LEVEL  = NOC_ALMOST_FULL
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [DATA_WIDTH-1:0]               in_data_i,
  input  logic                                in_valid_i,
  output logic                                in_ready_o,
  output logic [DATA_WIDTH-1:0]               out_data_o,
  output logic                                out_valid_o,
  input  logic                                out_ready_i,
  output logic [noc_count_w(DEPTH_LOG2)-1:0]  count_o,
  output logic                                almost_full_o,
  output logic                                almost_empty_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = noc_count_w(DEPTH_LOG2);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AE_LVL  = CW'(ALMOST_EMPTY_LEVEL);
  localparam logic [CW-1:0] AF_LVL  = CW'(ALMOST_FULL_LEVEL);

  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [CW-1:0]         count;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  empty;
  logic                  push;
  logic                  pop;

  assign empty      = (count == '0);
  // Readiness ignores out_ready_i: a full buffer refuses even when popping.
  assign in_ready_o = (count < DEPTH_C) & ~rst_i;

`ifdef NOC_BUF_BYPASS_EN
  logic pass;

  // Empty buffer with a consumer ready: the flit goes straight through.
  assign pass        = empty & in_valid_i & in_ready_o & out_ready_i;
  assign out_valid_o = ~empty | (in_valid_i & in_ready_o);
  assign out_data_o  = empty ? in_data_i : mem_rdata;
  assign push        = in_valid_i & in_ready_o & ~pass;
  assign pop         = ~empty & out_ready_i;
`else
  assign out_valid_o = ~empty;
  assign out_data_o  = mem_rdata;
  assign push        = in_valid_i & in_ready_o;
  assign pop         = out_valid_o & out_ready_i;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  noc_buf_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_mem (
    .clk_i   (clk_i),
    .we_i    (push),
    .waddr_i (wr_ptr),
    .wdata_i (in_data_i),
    .raddr_i (rd_ptr),
    .rdata_o (mem_rdata)
  );

  assign count_o        = count;
  assign almost_full_o  = (count >= AF_LVL);
  assign almost_empty_o = (count <= AE_LVL);

endmodule

// File: tb/tb_noc_input_buffer.sv
// Scoreboard bench for noc_input_buffer: directed phases plus random traffic
// against a queue-based occupancy model.
module tb_noc_input_buffer;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [4:0] count;
  logic       almost_full;
  logic       almost_empty;

  int checks = 0;
  int errors = 0;
  int model_count = 0;
  bit mon_en = 1'b0;
  logic [7:0] exp_q[$];

  noc_input_buffer dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .in_data_i      (in_data),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready),
    .out_data_o     (out_data),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .count_o        (count),
    .almost_full_o  (almost_full),
    .almost_empty_o (almost_empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change just after the rising edge; accepted flits enter the scoreboard.
  task automatic drive(input logic v, input logic [7:0] d, input logic r);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    if (v && model_count < DEPTH) exp_q.push_back(d);
  endtask

  // Monitor: compares at the falling edge, then advances the occupancy model.
  always @(negedge clk) begin
    if (mon_en) begin
      bit byp;
      bit push_m;
      bit pop_m;
      logic [7:0] e;
      byp = 1'b0;
`ifdef NOC_BUF_BYPASS_EN
      byp = (model_count == 0) && in_valid;
`endif
      chk("count", int'(count), model_count);
      chk("out_valid", int'(out_valid), int'((model_count != 0) || byp));
      chk("in_ready", int'(in_ready), int'(model_count < DEPTH));
      chk("almost_full", int'(almost_full), int'(model_count >= 14));
      chk("almost_empty", int'(almost_empty), int'(model_count <= 2));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("pop_underflow", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", int'(out_data), int'(e));
        end
      end
      push_m = in_valid && (model_count < DEPTH) && !(byp && out_ready);
      pop_m  = out_ready && (model_count != 0);
      model_count = model_count + int'(push_m) - int'(pop_m);
    end
  end

  initial begin
    // Power-on reset
    #2;
    chk("rst_count", int'(count), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_almost_empty", int'(almost_empty), 1);
    chk("rst_almost_full", int'(almost_full), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", int'(in_ready), 1);
    mon_en = 1'b1;

    // Fill 0x00..0x0F, then a refused 17th flit
    for (int i = 0; i < 16; i++) drive(1'b1, 8'(i), 1'b0);
    drive(1'b1, 8'h77, 1'b0);
    chk("full_count", int'(count), 16);
    chk("full_in_ready", int'(in_ready), 0);
    drive(1'b0, 8'h00, 1'b0);
    chk("full_refused_count", int'(count), 16);

    // Drain in order
    for (int i = 0; i < 18; i++) drive(1'b0, 8'h00, 1'b1);
    chk("drained_valid", int'(out_valid), 0);

    // Refill, then full plus pop: only the pop happens
    for (int i = 0; i < 16; i++) drive(1'b1, 8'(8'h40 + i), 1'b0);
    drive(1'b1, 8'h99, 1'b1);
    drive(1'b1, 8'h99, 1'b0);
    chk("full_pop_count", int'(count), 15);
    drive(1'b0, 8'h00, 1'b0);
    chk("full_pop_refill", int'(count), 16);
    for (int i = 0; i < 18; i++) drive(1'b0, 8'h00, 1'b1);

    // Bypass check from empty
    drive(1'b1, 8'hA5, 1'b1);
    #1;
`ifdef NOC_BUF_BYPASS_EN
    chk("bypass_valid", int'(out_valid), 1);
    chk("bypass_data", int'(out_data), 8'hA5);
`else
    chk("bypass_valid", int'(out_valid), 0);
`endif
    chk("bypass_count", int'(count), 0);
    drive(1'b0, 8'h00, 1'b1);
    drive(1'b0, 8'h00, 1'b1);

    // Simultaneous push/pop at count 8 across pointer wrap
    for (int i = 0; i < 8; i++) drive(1'b1, 8'($urandom), 1'b0);
    for (int i = 0; i < 40; i++) drive(1'b1, 8'($urandom), 1'b1);
    drive(1'b0, 8'h00, 1'b0);
    chk("simul_count", int'(count), 8);
    for (int i = 0; i < 10; i++) drive(1'b0, 8'h00, 1'b1);

    // Random traffic
    for (int i = 0; i < 2000; i++)
      drive(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 2) != 0));
    for (int i = 0; i < 20; i++) drive(1'b0, 8'h00, 1'b1);
    chk("sb_empty", exp_q.size(), 0);

    // Mid-stream reset at count 5
    for (int i = 0; i < 5; i++) drive(1'b1, 8'(8'h20 + i), 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    chk("pre_rst_count", int'(count), 5);
    @(posedge clk);
    #1;
    mon_en = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_count", int'(count), 0);
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_in_ready", int'(in_ready), 0);
    chk("mid_rst_almost_empty", int'(almost_empty), 1);
    exp_q.delete();
    model_count = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_post_rst_in_ready", int'(in_ready), 1);
    mon_en = 1'b1;
    drive(1'b1, 8'h3C, 1'b0);
    drive(1'b0, 8'h00, 1'b1);
    drive(1'b0, 8'h00, 1'b0);
    chk("after_rst_empty", int'(count), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
